alu_operand_loader: RTL
=======================

# alu_operand_loader

Front-end sequencer that sits directly upstream of the ALU on the lab board. It collects operand A, operand B and the operation code from the board switches, one value per debounced button press, and drives them to the ALU inputs. It then captures the ALU's combinational result and status flags (Y, C, V, N, Z) into registers for the display stage. The block owns the only button synchronizer and debouncer in the ALU datapath.

## Interface
- `BITS`, default 4: the ALU width parameter. Operand and result buses are `[BITS:0]` (BITS+1 bits), matching the ALU.
- `DEBOUNCE`, default 4: consecutive synchronized-high cycles required to accept a press. Must be ≥1. Board builds override it.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset; synchronous, active-high.
- `btn`, input, 1: raw asynchronous push-button.
- `sw`, input, BITS+1: operand switches. Sampled unsynchronized; they must be static around a press.
- `op_sw`, input, 4: operation switches. Same sampling rule as `sw`.
- `a`, output, BITS+1: registered operand A, to ALU `A`.
- `b`, output, BITS+1: registered operand B, to ALU `B`.
- `op`, output, 4: registered opcode, to ALU `Op`.
- `y_in`, input, BITS+1: ALU result.
- `c_in`, `v_in`, `n_in`, `z_in`, input, 1 each: ALU flags.
- `res_y`, output, BITS+1: captured result.
- `res_c`, `res_v`, `res_n`, `res_z`, output, 1 each: captured flags.
- `res_valid`, output, 1: one-cycle pulse on the cycle the result registers update.
- `state`, output, 3: current FSM state, for LEDs.

## Operation
- **Synchronizer.** `btn` passes through two flops to give `btn_s`.
- **Debounce counter.**
  - 0 whenever `btn_s`=0.
  - Increments while `btn_s`=1, saturating at DEBOUNCE.
  - `press` is high for exactly one cycle, when the counter steps from DEBOUNCE-1 to DEBOUNCE, and only if `armed`=1.
- **Armed flag.**
  - Cleared by reset and by each `press`.
  - Set when `btn_s`=0 is seen.
  - Effect: holding the button gives one press, and a button held through reset gives no press until it is released.
- **FSM states** (encoding on `state`): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A: on `press`, `a`←`sw`, go to S_B.
  - S_B: on `press`, `b`←`sw`, go to S_OP.
  - S_OP: on `press`, `op`←`op_sw`, go to S_EXEC.
  - S_EXEC: unconditional, one cycle. On exit, `res_*`←`y_in`/flags and `res_valid`=1 for that cycle. Go to S_SHOW.
  - S_SHOW: hold. On `press`, go to S_A.
- **Register retention.** `a`, `b`, `op` and `res_*` keep their values until they are explicitly reloaded. Returning to S_A does not clear them.
- **Ignored presses.** A `press` arriving while in S_EXEC is dropped; the counter and `armed` still update normally.
- **Undefined codes.** State codes 5–7 go to S_A on the next edge.
- **Reset.** Applies on any edge where `rst`=1, in any state. Values after reset:
  - `state`=S_A.
  - `a`, `b`, `op`, all `res_*`, `res_valid` = 0.
  - Synchronizer flops, counter and `armed` = 0.

## Timing
- **Press latency.** `btn` goes high before edge k and stays high. `btn_s` is first 1 after edge k+1. The counter reaches DEBOUNCE after edge k+1+DEBOUNCE, and `press` is high in that cycle. The load happens at edge k+2+DEBOUNCE.
- **Pulse rejection.** A high pulse on `btn` shorter than DEBOUNCE cycles, as seen on `btn_s`, produces no press.
- **ALU path.** `op` is loaded at edge t and the FSM is in S_EXEC during cycle t→t+1. The ALU is combinational, so `y_in` has settled from the new `a`/`b`/`op` within that cycle. `res_*` update at edge t+1, and `res_valid` is high during cycle t+1→t+2.
- **Press-to-valid.** From the op-load press edge, `res_valid` follows by one edge.
- **Turnaround.** The earliest next accepted press needs `btn_s` low for at least one cycle, then DEBOUNCE high cycles.

## Test plan
- Reset, then full sequence with BITS=4, DEBOUNCE=4: press with `sw`=5'd3, press with `sw`=5'd9, press with `op_sw`=4'd0, ALU model adding. Required: `a`=3, `b`=9, `op`=0; `res_y`=12, `res_z`=0; a single `res_valid` pulse exactly one edge after the op load; `state` sequence 0,1,2,3,4.
- Bounce: `btn` pulses high 3 cycles, low 2, high 3, with DEBOUNCE=4. Required: no press, `state` stays 0, `a` stays 0.
- Held button: `btn` held high 50 cycles in S_A. Required: exactly one load (`a`=`sw`), `state`=1 and no further advance until release plus a new DEBOUNCE-cycle press.
- Reset mid-operation: in S_OP with `a`=7, `b`=2, assert `rst` one cycle with `btn` held high. Required: all outputs 0, `state`=0 on the next edge, and no press until `btn` is released and re-pressed.
- Return loop: in S_SHOW, press. Required: `state`=0 with `a`, `b`, `op`, `res_*` unchanged. Reload only `a`=5'd1 and run through. Required: the new result uses the old `b`.
- Flag capture: ALU model returns `y_in`=0 with `z_in`=1, `c_in`=1. Required: `res_z`=1 and `res_c`=1 latched at the S_EXEC exit edge, and held while `z_in` toggles afterward.

Source files
------------

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced button sequencer loading ALU operands/opcode and capturing the ALU result and flags
module alu_operand_loader #(
  parameter int BITS     = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn,
  input  logic [BITS:0]   sw,
  input  logic [3:0]      op_sw,
  output logic [BITS:0]   a,
  output logic [BITS:0]   b,
  output logic [3:0]      op,
  input  logic [BITS:0]   y_in,
  input  logic            c_in,
  input  logic            v_in,
  input  logic            n_in,
  input  logic            z_in,
  output logic [BITS:0]   res_y,
  output logic            res_c,
  output logic            res_v,
  output logic            res_n,
  output logic            res_z,
  output logic            res_valid,
  output logic [2:0]      state
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;
  state_t          state_q, state_d;
  logic            s1_q, s2_q;
  logic [1:0]      fill_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            armed_q, armed_d, press_q, press_d;
  logic [BITS:0]   a_q, a_d, b_q, b_d, y_q, y_d;
  logic [3:0]      op_q, op_d;
  logic            c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d, valid_q, valid_d;
  // fill_q marks when the synchronizer holds real samples again after reset,
  // so the flushed zeros cannot arm a button that was held through reset
  always_comb begin
    cnt_d   = !s2_q ? '0 : (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1);
    press_d = s2_q && armed_q && cnt_q == CMAX - 1'b1;
    armed_d = (!s2_q && fill_q[1]) ? 1'b1 : (press_d ? 1'b0 : armed_q);
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    c_d     = c_q;
    v_d     = v_q;
    n_d     = n_q;
    z_d     = z_q;
    valid_d = 1'b0;
    case (state_q)
      S_A: if (press_q) begin
        a_d     = sw;
        state_d = S_B;
      end
      S_B: if (press_q) begin
        b_d     = sw;
        state_d = S_OP;
      end
      S_OP: if (press_q) begin
        op_d    = op_sw;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        y_d     = y_in;
        c_d     = c_in;
        v_d     = v_in;
        n_d     = n_in;
        z_d     = z_in;
        valid_d = 1'b1;
        state_d = S_SHOW;
      end
      S_SHOW: state_d = press_q ? S_A : S_SHOW;
      default: state_d = S_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      fill_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= btn;
      s2_q    <= s1_q;
      fill_q  <= {fill_q[0], 1'b1};
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      c_q     <= c_d;
      v_q     <= v_d;
      n_q     <= n_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  end
  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign res_y     = y_q;
  assign res_c     = c_q;
  assign res_v     = v_q;
  assign res_n     = n_q;
  assign res_z     = z_q;
  assign res_valid = valid_q;
  assign state     = state_q;
endmodule
